// File: rtl/combat_pkg.sv
// combat_pkg: shared state type, default parameters and health-bar encoder for combat_controller
package combat_pkg;
  typedef enum logic [1:0] {IDLE, FIGHT, KO} combat_state_t;
  localparam int MAX_HEALTH_DEF = 5;
  localparam int HIT_COOLDOWN_DEF = 30;
  localparam int DAMAGE_DEF = 1;
  localparam int REGEN_FRAMES_DEF = 120;
  function automatic logic [14:0] health_to_mask(input logic [3:0] h);
    logic [14:0] m;
    for (int i = 0; i < 15; i++) m[i] = i < int'(h);
    return m;
  endfunction
endpackage

// File: rtl/combat_pool.sv
// combat_pool: one character's hit edge detect, cooldown, health register and bar mask
// Optional regeneration counter enabled by COMBAT_CTRL_REGEN_EN.
module combat_pool
  import combat_pkg::*;
#(
  parameter int MAX_HEALTH = MAX_HEALTH_DEF,
  parameter int HIT_COOLDOWN = HIT_COOLDOWN_DEF,
  parameter int DAMAGE = DAMAGE_DEF,
  parameter int REGEN_FRAMES = REGEN_FRAMES_DEF,
  parameter int HW = $clog2(MAX_HEALTH + 1)
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  clear,
  input  logic                  fight,
  input  logic                  tick,
  input  logic                  contact,
  output logic [HW-1:0]         health,
  output logic [MAX_HEALTH-1:0] mask,
  output logic                  accept
);
  localparam logic [HW-1:0] MAXH = HW'(MAX_HEALTH);
  localparam logic [HW-1:0] DMG = HW'(DAMAGE);
  localparam logic [7:0] CD = 8'(HIT_COOLDOWN);
  logic contact_r, contact_q, regen_up;
  logic [7:0] cooldown;
  // contact_r is the input register; the edge is taken between it and its delayed copy
  assign accept = fight & contact_r & ~contact_q & (cooldown == '0);
  assign mask = MAX_HEALTH'(health_to_mask(4'(health)));
`ifdef COMBAT_CTRL_REGEN_EN
  localparam int RW = $clog2(REGEN_FRAMES + 1);
  logic [RW-1:0] regen_cnt;
  assign regen_up = fight & tick & (health != '0) & (regen_cnt == RW'(REGEN_FRAMES - 1));
  always_ff @(posedge Clk) begin
    if (!Reset_n || clear || accept) regen_cnt <= '0;
    else if (fight && tick && health != '0) regen_cnt <= regen_up ? '0 : regen_cnt + 1'b1;
  end
`else
  assign regen_up = 1'b0;
`endif
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      contact_r <= 1'b0;
      contact_q <= 1'b0;
    end else begin
      contact_r <= contact;
      contact_q <= contact_r;
    end
  end
  always_ff @(posedge Clk) begin
    if (!Reset_n || clear) begin
      health <= MAXH;
      cooldown <= '0;
    end else if (accept) begin
      health <= health > DMG ? health - DMG : '0;
      cooldown <= CD;
    end else begin
      if (tick && cooldown != '0) cooldown <= cooldown - 8'd1;
      if (regen_up && health != MAXH) health <= health + 1'b1;
    end
  end
endmodule

// File: rtl/combat_controller.sv
// combat_controller: fight FSM turning contact edges into damage, health bars and dead flags
// Define COMBAT_CTRL_REGEN_EN to enable slow health regeneration during the fight.
module combat_controller
  import combat_pkg::*;
#(
  parameter int MAX_HEALTH = MAX_HEALTH_DEF,
  parameter int HIT_COOLDOWN = HIT_COOLDOWN_DEF,
  parameter int DAMAGE = DAMAGE_DEF,
  parameter int REGEN_FRAMES = REGEN_FRAMES_DEF,
  localparam int HW = $clog2(MAX_HEALTH + 1)
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  frame_clk,
  input  logic                  battle_l,
  input  logic                  Restart,
  input  logic                  npc_contact,
  input  logic                  player_contact,
  output logic [HW-1:0]         Player_Health,
  output logic [HW-1:0]         NPC_Health,
  output logic [MAX_HEALTH-1:0] is_player_health_seg,
  output logic [MAX_HEALTH-1:0] is_npc_health_seg,
  output logic                  Player_Dead,
  output logic                  NPC_Dead,
  output logic                  proj_clear
);
  combat_state_t state, state_nx;
  logic frame_q, tick, fight, clear, npc_accept, unused_player_accept;
  assign tick = frame_clk & ~frame_q;
  assign fight = (state == FIGHT) & ~Restart;
  assign clear = Restart | (state == IDLE);
  always_comb begin
    state_nx = Restart ? IDLE :
               state == IDLE ? (battle_l ? FIGHT : IDLE) :
               state == FIGHT ? ((Player_Health == '0 || NPC_Health == '0) ? KO : battle_l ? FIGHT : IDLE) :
               KO;
  end
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state <= IDLE;
      frame_q <= 1'b0;
      proj_clear <= 1'b0;
      Player_Dead <= 1'b0;
      NPC_Dead <= 1'b0;
    end else begin
      state <= state_nx;
      frame_q <= frame_clk;
      proj_clear <= npc_accept;
      Player_Dead <= !Restart && Player_Health == '0;
      NPC_Dead <= !Restart && NPC_Health == '0;
    end
  end
  combat_pool #(
    .MAX_HEALTH(MAX_HEALTH), .HIT_COOLDOWN(HIT_COOLDOWN), .DAMAGE(DAMAGE),
    .REGEN_FRAMES(REGEN_FRAMES), .HW(HW)
  ) u_player (
    .Clk(Clk), .Reset_n(Reset_n), .clear(clear), .fight(fight), .tick(tick),
    .contact(player_contact), .health(Player_Health), .mask(is_player_health_seg),
    .accept(unused_player_accept)
  );
  combat_pool #(
    .MAX_HEALTH(MAX_HEALTH), .HIT_COOLDOWN(HIT_COOLDOWN), .DAMAGE(DAMAGE),
    .REGEN_FRAMES(REGEN_FRAMES), .HW(HW)
  ) u_npc (
    .Clk(Clk), .Reset_n(Reset_n), .clear(clear), .fight(fight), .tick(tick),
    .contact(npc_contact), .health(NPC_Health), .mask(is_npc_health_seg),
    .accept(npc_accept)
  );
endmodule

// File: tb/tb_combat_controller.sv
// tb_combat_controller: directed table, corner sequences and randomized model check of combat_controller
module tb_combat_controller;
  import combat_pkg::*;
  localparam int MH = 5, HC = 30, DMG = 1, RF = 120;
`ifdef COMBAT_CTRL_REGEN_EN
  localparam bit REGEN = 1'b1;
`else
  localparam bit REGEN = 1'b0;
`endif
  logic Clk = 0, Reset_n = 0, frame_clk = 0, battle_l = 0, Restart = 0;
  logic npc_contact = 0, player_contact = 0;
  logic [2:0] Player_Health, NPC_Health;
  logic [4:0] is_player_health_seg, is_npc_health_seg;
  logic Player_Dead, NPC_Dead, proj_clear;
  int n_chk = 0, n_fail = 0, pc;
  int mh[2], cd[2], rg[2];
  bit ko;

  combat_controller dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .battle_l(battle_l), .Restart(Restart),
    .npc_contact(npc_contact), .player_contact(player_contact),
    .Player_Health(Player_Health), .NPC_Health(NPC_Health),
    .is_player_health_seg(is_player_health_seg), .is_npc_health_seg(is_npc_health_seg),
    .Player_Dead(Player_Dead), .NPC_Dead(NPC_Dead), .proj_clear(proj_clear)
  );

  always #5 Clk = ~Clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  typedef struct {
    string name;
    int ticks;
    bit restart;
    bit npc;
    bit ply;
    int hold;
    int exp_ply;
    int exp_npc;
    int exp_pc;
  } vec_t;
  vec_t vt[12];

  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int ep, input int en);
    chk({tag, " player_health"}, int'(Player_Health), ep);
    chk({tag, " npc_health"}, int'(NPC_Health), en);
    chk({tag, " player_mask"}, int'(is_player_health_seg), (1 << ep) - 1);
    chk({tag, " npc_mask"}, int'(is_npc_health_seg), (1 << en) - 1);
    chk({tag, " player_dead"}, int'(Player_Dead), ep == 0 ? 1 : 0);
    chk({tag, " npc_dead"}, int'(NPC_Dead), en == 0 ? 1 : 0);
  endtask

  task automatic pulse_ticks(input int k);
    for (int i = 0; i < k; i++) begin
      frame_clk = 1;
      step(1);
      frame_clk = 0;
      step(1);
    end
  endtask

  task automatic hit(input bit n, input bit p, input int hold);
    pc = 0;
    npc_contact = n;
    player_contact = p;
    for (int i = 0; i < hold; i++) begin
      step(1);
      pc += int'(proj_clear);
    end
    npc_contact = 0;
    player_contact = 0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      pc += int'(proj_clear);
    end
  endtask

  task automatic do_restart();
    Restart = 1;
    step(1);
    Restart = 0;
    step(2);
  endtask

  task automatic m_refill();
    for (int c = 0; c < 2; c++) begin
      mh[c] = MH;
      cd[c] = 0;
      rg[c] = 0;
    end
    ko = 0;
  endtask

  task automatic m_ticks(input int k);
    for (int i = 0; i < k; i++)
      if (!ko)
        for (int c = 0; c < 2; c++) begin
          if (cd[c] > 0) cd[c]--;
          if (REGEN && mh[c] > 0) begin
            rg[c]++;
            if (rg[c] == RF) begin
              rg[c] = 0;
              if (mh[c] < MH) mh[c]++;
            end
          end
        end
  endtask

  task automatic m_hit(input bit n, input bit p, output int epc);
    epc = 0;
    if (!ko) begin
      for (int c = 0; c < 2; c++)
        if ((c == 1 ? n : p) && cd[c] == 0) begin
          mh[c] = mh[c] > DMG ? mh[c] - DMG : 0;
          cd[c] = HC;
          rg[c] = 0;
          if (c == 1) epc = 1;
        end
      if (mh[0] == 0 || mh[1] == 0) ko = 1;
    end
  endtask

  initial begin
    bit found;
    int epc;
    vt[0]  = '{"held_contact", 0, 1'b0, 1'b1, 1'b0, 10, 5, 4, 1};
    vt[1]  = '{"cooldown_ignore", 5, 1'b0, 1'b1, 1'b0, 3, 5, 4, 0};
    vt[2]  = '{"after_cooldown", 31, 1'b0, 1'b1, 1'b0, 3, 5, 3, 1};
    vt[3]  = '{"npc_hit3", 31, 1'b0, 1'b1, 1'b0, 3, 5, 2, 1};
    vt[4]  = '{"npc_hit4", 31, 1'b0, 1'b1, 1'b0, 3, 5, 1, 1};
    vt[5]  = '{"npc_ko", 31, 1'b0, 1'b1, 1'b0, 3, 5, 0, 1};
    vt[6]  = '{"ko_ignore", 31, 1'b0, 1'b1, 1'b0, 3, 5, 0, 0};
    vt[7]  = '{"restart", 0, 1'b1, 1'b0, 1'b0, 0, 5, 5, 0};
    vt[8]  = '{"both1", 0, 1'b0, 1'b1, 1'b1, 3, 4, 4, 1};
    vt[9]  = '{"both2", 31, 1'b0, 1'b1, 1'b1, 3, 3, 3, 1};
    vt[10] = '{"both3", 31, 1'b0, 1'b1, 1'b1, 3, 2, 2, 1};
    vt[11] = '{"both4", 31, 1'b0, 1'b1, 1'b1, 3, 1, 1, 1};

    step(2);
    check_all("reset", 5, 5);
    chk("reset proj_clear", int'(proj_clear), 0);
    chk("reset state", int'(dut.state), int'(IDLE));
    Reset_n = 1;
    battle_l = 1;
    step(1);
    chk("enter fight", int'(dut.state), int'(FIGHT));

    foreach (vt[i]) begin
      if (vt[i].restart) begin
        Restart = 1;
        step(1);
        chk({vt[i].name, " state_idle"}, int'(dut.state), int'(IDLE));
        chk({vt[i].name, " npc_dead_clr"}, int'(NPC_Dead), 0);
        Restart = 0;
        step(2);
      end
      pulse_ticks(vt[i].ticks);
      hit(vt[i].npc, vt[i].ply, vt[i].hold);
      check_all(vt[i].name, vt[i].exp_ply, vt[i].exp_npc);
      chk({vt[i].name, " proj_clear_pulses"}, pc, vt[i].exp_pc);
      if (vt[i].exp_ply == 0 || vt[i].exp_npc == 0)
        chk({vt[i].name, " state_ko"}, int'(dut.state), int'(KO));
    end

    pulse_ticks(31);
    npc_contact = 1;
    player_contact = 1;
    found = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      step(1);
      if (Player_Dead || NPC_Dead) begin
        found = 1;
        chk("double_ko player_dead", int'(Player_Dead), 1);
        chk("double_ko npc_dead", int'(NPC_Dead), 1);
      end
    end
    if (!found) chk("double_ko seen", 0, 1);
    npc_contact = 0;
    player_contact = 0;
    step(3);
    check_all("double_ko", 0, 0);
    do_restart();

    npc_contact = 1;
    step(1);
    chk("latency 1cyc", int'(NPC_Health), 5);
    chk("latency 1cyc proj_clear", int'(proj_clear), 0);
    step(1);
    chk("latency 2cyc", int'(NPC_Health), 4);
    chk("proj_clear on", int'(proj_clear), 1);
    step(1);
    chk("proj_clear off", int'(proj_clear), 0);
    npc_contact = 0;
    step(2);

    pulse_ticks(31);
    hit(1, 0, 3);
    pulse_ticks(31);
    hit(1, 0, 3);
    chk("pre_reset npc", int'(NPC_Health), 2);
    pulse_ticks(3);
    Reset_n = 0;
    step(1);
    chk("mid_reset npc", int'(NPC_Health), 5);
    chk("mid_reset cooldown", int'(dut.u_npc.cooldown), 0);
    chk("mid_reset state", int'(dut.state), int'(IDLE));
    Reset_n = 1;
    step(2);
    hit(1, 0, 3);
    chk("post_reset hit", int'(NPC_Health), 4);

`ifdef COMBAT_CTRL_REGEN_EN
    pulse_ticks(31);
    hit(1, 0, 3);
    chk("regen base", int'(NPC_Health), 3);
    pulse_ticks(RF - 1);
    chk("regen early", int'(NPC_Health), 3);
    pulse_ticks(1);
    chk("regen step", int'(NPC_Health), 4);
`endif

    Reset_n = 0;
    step(2);
    Reset_n = 1;
    step(2);
    m_refill();
    for (int i = 0; i < 250; i++) begin
      int op;
      op = $urandom_range(0, 15);
      if (op <= 6) begin
        int k;
        k = $urandom_range(1, 12);
        pulse_ticks(k);
        m_ticks(k);
        check_all("rand ticks", mh[0], mh[1]);
      end else if (op <= 13) begin
        bit n, p;
        n = (op <= 9) || (op >= 12);
        p = (op >= 10);
        hit(n, p, $urandom_range(2, 6));
        m_hit(n, p, epc);
        check_all("rand hit", mh[0], mh[1]);
        chk("rand proj_clear", pc, epc);
      end else if (op == 14) begin
        do_restart();
        m_refill();
        check_all("rand restart", mh[0], mh[1]);
      end else begin
        battle_l = 0;
        step(2);
        battle_l = 1;
        step(2);
        if (!ko) m_refill();
        check_all("rand battle", mh[0], mh[1]);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/combat_controller.md
Name: combat_controller

Overview:
- Sequences the fight: converts raw contact signals (projectile→NPC, NPC→player) into damage events, tracks both health pools, and drives the health-bar segment masks.
- Generates the Player_Dead / NPC_Dead flags that stage_control consumes; these replace the debug switches.
- Issues a projectile-clear pulse on each accepted hit so the projectile block rearms.
- Sits between the hitbox instances and stage_control / health / color_mapper; clocked by Clk, with frame timing derived from VGA_VS.

Parameters:
- MAX_HEALTH, 5, starting health and number of bar segments per character (1..15)
- HIT_COOLDOWN, 30, invulnerability frames after an accepted hit (1..255)
- DAMAGE, 1, health removed per accepted hit (1..MAX_HEALTH)
- REGEN_FRAMES, 120, frames without damage before +1 regen (optional feature only)

Ports:
- Clk  in  1  system clock (50 MHz)
- Reset_n  in  1  synchronous active-low reset
- frame_clk  in  1  VGA_VS; a rising edge sampled in Clk = one frame tick
- battle_l  in  1  stage_control battle-state level
- Restart  in  1  level; refills health and clears dead flags
- npc_contact  in  1  projectile overlaps NPC (level, from hitbox)
- player_contact  in  1  NPC attack overlaps player (level)
- Player_Health  out  HW  current player health, HW = $clog2(MAX_HEALTH+1)
- NPC_Health  out  HW  current NPC health
- is_player_health_seg  out  MAX_HEALTH  thermometer mask; bit i = 1 iff i < Player_Health
- is_npc_health_seg  out  MAX_HEALTH  same for NPC
- Player_Dead  out  1  player health reached 0
- NPC_Dead  out  1  NPC health reached 0
- proj_clear  out  1  one-Clk pulse when an npc_contact hit is accepted

Behaviour:
- All state updates on posedge Clk. Reset_n low at a clock edge: both healths = MAX_HEALTH, cooldowns = 0, dead flags = 0, proj_clear = 0, state = IDLE. Reset mid-fight aborts immediately.
- Frame tick: register frame_clk; tick = frame_clk & ~frame_clk_q (one Clk cycle).
- Contact edges: register each contact input; hit_req = contact & ~contact_q. A held overlap produces one request only.
- FSM:
  - IDLE: healths held at MAX_HEALTH, requests ignored. Go to FIGHT when battle_l = 1.
  - FIGHT: process hits. Go to KO when either health = 0. Go to IDLE when battle_l = 0.
  - KO: hits ignored, dead flags held. Go to IDLE on Restart.
- Restart has priority over everything except reset in any state: healths = MAX, flags = 0, cooldowns = 0, next state IDLE.
- Hit acceptance (FIGHT only, per character, independent):
  - Accept when hit_req = 1 and that character's cooldown = 0.
  - Health: subtract DAMAGE, saturating at 0 (no wrap).
  - Cooldown loads HIT_COOLDOWN.
  - For NPC hits, proj_clear = 1 on the following cycle.
  - A request arriving while cooldown ≠ 0 is discarded, not queued.
- Cooldown: decrements by 1 on each tick while nonzero. A tick and an accepted hit in the same cycle: the load wins.
- Latency: contact rising edge → health updates 2 Clk cycles later (input register + update register).
- Dead flags: registered; set the cycle after the health register reads 0.
  - Simultaneous final hits set both flags in the same cycle (double KO); stage_control resolves priority.
- Masks: combinational from the health registers. MAX_HEALTH bits, LSB = first segment.

Optional Feature:
- Macro COMBAT_CTRL_REGEN_EN.
- Defined: per-character idle counter counts ticks since that character's last accepted hit, in FIGHT only. At REGEN_FRAMES it adds +1 health (saturating at MAX_HEALTH) and restarts the count.
  - Counter clears on an accepted hit, Restart and reset.
  - No regen in KO or IDLE, and never from 0 health.
- Undefined: no counters; health only decreases until Restart.

Decomposition:
- Package combat_pkg holds:
  - typedef enum logic [1:0] {IDLE, FIGHT, KO} combat_state_t
  - default parameter constants
  - function health_to_mask (thermometer encode)
- Sub-module combat_pool: one instance per character, containing edge detector, cooldown counter, health register, regen counter and mask.
- Top-level combat_controller holds the FSM, frame-tick detector and proj_clear.

Test Plan:
- Reset_n = 0 for 2 cycles, then battle_l = 1 → Player_Health = NPC_Health = 5, masks = 5'b11111, flags = 0; state FIGHT after 1 cycle.
- npc_contact held high 10 cycles → exactly one hit: NPC_Health = 4, mask = 5'b01111, exactly one proj_clear pulse.
- Second npc_contact edge after 5 frame ticks → ignored (health stays 4). Edge after 31 ticks → NPC_Health = 3.
- Five accepted NPC hits spaced 31 ticks apart → NPC_Health = 0, NPC_Dead = 1, state KO. A further edge changes nothing. Restart → NPC_Health = 5, NPC_Dead = 0, IDLE.
- Both contacts rise in the same cycle with both healths = 1 → both healths = 0 and both dead flags set in the same cycle.
- Reset_n = 0 mid-cooldown with NPC_Health = 2 → next cycle NPC_Health = 5, cooldown 0. With COMBAT_CTRL_REGEN_EN defined: NPC at 3, 120 ticks without hits → NPC_Health = 4.
